// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared encodings and default width for the calculator datapath
package calc_pkg;

  // Default operand width; results are twice this width.
  localparam int CALC_W = 8;

  // Operation select encodings shared by the datapath and its control FSM.
  typedef enum logic [1:0] {
    FCT_ADD = 2'b00,
    FCT_SUB = 2'b01,
    FCT_MUL = 2'b10,
    FCT_DIV = 2'b11
  } fct_e;

endpackage

// File: rtl/calc_div.sv
// rtl/calc_div.sv - restoring divider, one quotient bit per clock
module calc_div
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div0
);

  localparam int CW = $clog2(W) + 1;

  logic [CW-1:0] cnt;
  logic          first;
  logic [W-1:0]  rem_r;
  logic [W-1:0]  quo_r;
  logic [W-1:0]  src_r;
  logic [W-1:0]  src_q;
  logic [W:0]    shifted;
  logic [W-1:0]  nxt_r;
  logic [W-1:0]  nxt_q;
  logic          qbit;

  // One restoring step; the first step seeds from zero and the live dividend
  // so that operands loaded on the start edge are still honoured.
  always_comb begin
    src_r   = first ? '0 : rem_r;
    src_q   = first ? a : quo_r;
    shifted = {src_r, src_q[W-1]};
    qbit    = 1'b0;
    nxt_r   = shifted[W-1:0];
    if (shifted >= {1'b0, b}) begin
      qbit  = 1'b1;
      nxt_r = shifted[W-1:0] - b;
    end
    nxt_q = {src_q[W-2:0], qbit};
  end

  // Iteration control: start/abort override, then W steps while busy.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      busy  <= 1'b0;
      first <= 1'b0;
      cnt   <= '0;
      rem_r <= '0;
      quo_r <= '0;
      div0  <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      first <= 1'b1;
      cnt   <= '0;
      div0  <= 1'b0;
    end else if (abort) begin
      busy  <= 1'b0;
      first <= 1'b0;
      div0  <= 1'b0;
    end else if (busy) begin
      rem_r <= nxt_r;
      quo_r <= nxt_q;
      first <= 1'b0;
      cnt   <= cnt + CW'(1);
      if (first) begin
        div0 <= (b == '0);
      end
      if (cnt == CW'(W - 1)) begin
        busy <= 1'b0;
      end
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/calc_datapath.sv
// rtl/calc_datapath.sv - operand/result register bank with deferred result writes
module calc_datapath
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic           clock_i,
  input  logic           reset_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic [1:0]     fct_i,
  input  logic           a_we_i,
  input  logic           a_rst_i,
  input  logic           b_we_i,
  input  logic           b_rst_i,
  input  logic           fct_we_i,
  input  logic           fct_rst_i,
  input  logic           res_we_i,
  input  logic           res_rst_i,
  input  logic           rem_we_i,
  input  logic           rem_rst_i,
  input  logic           done_we_i,
  input  logic           done_rst_i,
  output logic [2*W-1:0] res_o,
  output logic [W-1:0]   rem_o,
  output logic           done_o,
  output logic           busy_o,
  output logic           div0_o
);

  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  fct_e           f_q;
  fct_e           op_q;
  logic           load_f;
  logic           start_div;
  logic           abort_div;
  logic           alu_busy;
  logic [2*W-1:0] alu_res;
  logic [2*W-1:0] alu_q;
  logic           div_busy;
  logic [W-1:0]   div_quo;
  logic [W-1:0]   div_rem;
  logic           div_zero;
  logic [2*W-1:0] res_int;
  logic [W-1:0]   rem_int;
  logic           res_pend;
  logic           rem_pend;
  logic           done_pend;

  // A load of F (not masked by its clear) starts or restarts a computation.
  assign load_f    = fct_we_i & fct_rst_i;
  assign start_div = load_f & (fct_i == FCT_DIV);
  assign abort_div = load_f & (fct_i != FCT_DIV);

  assign busy_o = alu_busy | div_busy;
  assign div0_o = div_zero;

  // Operand registers: clear has priority over load.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      a_q  <= '0;
      b_q  <= '0;
      f_q  <= FCT_ADD;
      op_q <= FCT_ADD;
    end else begin
      if (!a_rst_i)      a_q <= '0;
      else if (a_we_i)   a_q <= a_i;
      if (!b_rst_i)      b_q <= '0;
      else if (b_we_i)   b_q <= b_i;
      if (!fct_rst_i)    f_q <= FCT_ADD;
      else if (fct_we_i) f_q <= fct_e'(fct_i);
      if (load_f)        op_q <= fct_e'(fct_i);
    end
  end

  // Single-cycle operations on the registered operands.
  always_comb begin
    alu_res = '0;
    case (f_q)
      FCT_ADD: alu_res = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
      FCT_SUB: alu_res = {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
      FCT_MUL: alu_res = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
      default: alu_res = '0;
    endcase
  end

  // Single-cycle op tracking: busy for exactly the cycle after the F load.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      alu_busy <= 1'b0;
      alu_q    <= '0;
    end else if (load_f) begin
      alu_busy <= (fct_i != FCT_DIV);
    end else if (alu_busy) begin
      alu_q    <= alu_res;
      alu_busy <= 1'b0;
    end
  end

  calc_div #(
    .W (W)
  ) u_div (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .start     (start_div),
    .abort     (abort_div),
    .a         (a_q),
    .b         (b_q),
    .busy      (div_busy),
    .quotient  (div_quo),
    .remainder (div_rem),
    .div0      (div_zero)
  );

  // Internal result follows whichever unit ran the most recent operation.
  always_comb begin
    res_int = alu_q;
    rem_int = '0;
    if (op_q == FCT_DIV) begin
      res_int = {{W{1'b0}}, div_quo};
      rem_int = div_rem;
    end
  end

  // Result registers: load when idle, otherwise remember the request until idle.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      res_o     <= '0;
      rem_o     <= '0;
      done_o    <= 1'b0;
      res_pend  <= 1'b0;
      rem_pend  <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      if (!res_rst_i) begin
        res_o    <= '0;
        res_pend <= 1'b0;
      end else if (!busy_o) begin
        if (res_we_i || res_pend) res_o <= res_int;
        res_pend <= 1'b0;
      end else if (res_we_i) begin
        res_pend <= 1'b1;
      end

      if (!rem_rst_i) begin
        rem_o    <= '0;
        rem_pend <= 1'b0;
      end else if (!busy_o) begin
        if (rem_we_i || rem_pend) rem_o <= rem_int;
        rem_pend <= 1'b0;
      end else if (rem_we_i) begin
        rem_pend <= 1'b1;
      end

      if (!done_rst_i) begin
        done_o    <= 1'b0;
        done_pend <= 1'b0;
      end else if (!busy_o) begin
        if (done_we_i || done_pend) done_o <= 1'b1;
        done_pend <= 1'b0;
      end else if (done_we_i) begin
        done_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_datapath.sv
// tb/tb_calc_datapath.sv - self-checking bench for calc_datapath
module tb_calc_datapath;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [7:0]  a_i, b_i;
  logic [1:0]  fct_i;
  logic        a_we_i, a_rst_i, b_we_i, b_rst_i, fct_we_i, fct_rst_i;
  logic        res_we_i, res_rst_i, rem_we_i, rem_rst_i, done_we_i, done_rst_i;
  logic [15:0] res_o;
  logic [7:0]  rem_o;
  logic        done_o, busy_o, div0_o;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] m_res = '0;

  calc_datapath #(.W(8)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .a_i(a_i), .b_i(b_i), .fct_i(fct_i),
    .a_we_i(a_we_i), .a_rst_i(a_rst_i), .b_we_i(b_we_i), .b_rst_i(b_rst_i),
    .fct_we_i(fct_we_i), .fct_rst_i(fct_rst_i),
    .res_we_i(res_we_i), .res_rst_i(res_rst_i), .rem_we_i(rem_we_i), .rem_rst_i(rem_rst_i),
    .done_we_i(done_we_i), .done_rst_i(done_rst_i),
    .res_o(res_o), .rem_o(rem_o), .done_o(done_o), .busy_o(busy_o), .div0_o(div0_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick;
    @(posedge clock_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_res(input int a, input int b, input int f);
    case (f)
      0:       return 16'(a + b);
      1:       return 16'(a - b);
      2:       return 16'(a * b);
      default: return (b == 0) ? 16'h00FF : 16'(a / b);
    endcase
  endfunction

  function automatic logic [7:0] ref_rem(input int a, input int b, input int f);
    if (f != 3) return 8'd0;
    return (b == 0) ? 8'(a) : 8'(a % b);
  endfunction

  task automatic load_ab(input int a, input int b);
    a_i = 8'(a); b_i = 8'(b); a_we_i = 1; b_we_i = 1; done_rst_i = 0;
    tick;
    a_we_i = 0; b_we_i = 0; done_rst_i = 1;
  endtask

  task automatic load_f(input int f);
    fct_i = 2'(f); fct_we_i = 1;
    tick;
    fct_we_i = 0;
  endtask

  // Full operation: result enables raised so they are sampled at edge k+we_at.
  task automatic run_op(input int a, input int b, input int f, input int we_at);
    int lat, commit;
    logic [15:0] er;
    logic [7:0]  em;
    load_ab(a, b);
    check("done_clr", done_o, 0);
    load_f(f);
    check("busy_start", busy_o, 1);
    lat    = (f == 3) ? 8 : 1;
    commit = (we_at > lat + 1) ? we_at : lat + 1;
    er     = ref_res(a, b, f);
    em     = ref_rem(a, b, f);
    for (int c = 1; c <= commit; c++) begin
      if (c == we_at) begin res_we_i = 1; rem_we_i = 1; done_we_i = 1; end
      tick;
      res_we_i = 0; rem_we_i = 0; done_we_i = 0;
      if (c < commit) begin
        check("res_hold", res_o, m_res);
        check("done_hold", done_o, 0);
        check("busy_window", busy_o, c < lat);
      end
    end
    check("res", res_o, er);
    check("rem", rem_o, em);
    check("done", done_o, 1);
    check("div0", div0_o, (f == 3 && b == 0));
    check("busy_end", busy_o, 0);
    m_res = er;
  endtask

  initial begin
    reset_i = 0;
    a_i = 0; b_i = 0; fct_i = 0;
    a_we_i = 0; b_we_i = 0; fct_we_i = 0; res_we_i = 0; rem_we_i = 0; done_we_i = 0;
    a_rst_i = 1; b_rst_i = 1; fct_rst_i = 1; res_rst_i = 1; rem_rst_i = 1; done_rst_i = 1;
    tick; tick;
    check("rst_res", res_o, 0);
    check("rst_rem", rem_o, 0);
    check("rst_done", done_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_div0", div0_o, 0);
    reset_i = 1;
    tick; tick; tick;
    check("idle_busy", busy_o, 0);

    run_op(200, 100, 0, 2);
    run_op(5, 7, 1, 2);
    run_op(255, 255, 2, 2);
    run_op(200, 7, 3, 2);
    run_op(9, 0, 3, 2);
    run_op(0, 255, 1, 1);
    run_op(255, 1, 3, 9);

    for (int i = 0; i < 16; i++) begin
      int ra, rb, rf, rw;
      ra = int'($urandom_range(255));
      rb = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255));
      rf = int'($urandom_range(3));
      rw = int'($urandom_range(10, 1));
      run_op(ra, rb, rf, rw);
    end

    // Abort a division with an add; the pending result write must survive.
    load_ab(100, 3);
    load_f(3);
    tick; tick;
    res_we_i = 1;
    tick;
    res_we_i = 0;
    check("abort_res_deferred", res_o, m_res);
    load_f(0);
    check("abort_busy", busy_o, 1);
    tick;
    check("abort_busy_low", busy_o, 0);
    check("abort_res_hold", res_o, m_res);
    tick;
    check("abort_res", res_o, 16'd103);
    check("abort_done_not_pending", done_o, 0);
    check("abort_div0", div0_o, 0);
    m_res = 16'd103;

    // A clear while busy drops the pending write.
    load_ab(50, 5);
    load_f(3);
    tick;
    res_we_i = 1;
    tick;
    res_we_i = 0; res_rst_i = 0;
    tick;
    res_rst_i = 1;
    check("pend_clr_res", res_o, 0);
    for (int i = 0; i < 10; i++) tick;
    check("pend_clr_no_commit", res_o, 0);
    check("pend_clr_busy", busy_o, 0);
    m_res = '0;

    // Asynchronous reset in the middle of a deferred division.
    run_op(13, 4, 3, 12);
    a_i = 8'd200; b_i = 8'd7; a_we_i = 1; b_we_i = 1;
    tick;
    a_we_i = 0; b_we_i = 0;
    load_f(3);
    tick;
    res_we_i = 1; rem_we_i = 1; done_we_i = 1;
    tick;
    res_we_i = 0; rem_we_i = 0; done_we_i = 0;
    tick;
    @(posedge clock_i);
    reset_i = 0;
    #1;
    check("arst_res", res_o, 0);
    check("arst_rem", rem_o, 0);
    check("arst_done", done_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_div0", div0_o, 0);
    tick; tick;
    reset_i = 1;
    for (int i = 0; i < 15; i++) tick;
    check("post_rst_res", res_o, 0);
    check("post_rst_rem", rem_o, 0);
    check("post_rst_done", done_o, 0);
    check("post_rst_busy", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
